// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the frame timer and its axis counters.
package vga_pkg;

    // Width of the x/y raster counters; every axis total must fit in it.
    localparam int unsigned COORD_W = 10;

    // Default 640x480 @ 60 Hz horizontal timing, in pixel ticks.
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    // Default vertical timing, in lines.
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    // Length of one axis period: visible region plus porches and sync.
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus registered sync and
// visible-region decodes. The decodes are computed from the counter's next value,
// so they change on the same clock as the count and never lag it.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FP     = H_FP_DEF,
    parameter int unsigned SYNC   = H_SYNC_DEF,
    parameter int unsigned BP     = H_BP_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap,
    output logic               sync_n,
    output logic               in_active
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);
    localparam logic [COORD_W-1:0] ACTIVE_END = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] ONE        = COORD_W'(1);

    logic [COORD_W-1:0] cnt_r;
    logic [COORD_W-1:0] cntNext_s;
    logic               wrap_s;
    logic               syncN_r;
    logic               inActive_r;

    // Next count: hold without inc, wrap to zero after the last position.
    always_comb begin
        wrap_s    = inc && (cnt_r == LAST);
        cntNext_s = cnt_r;
        if (!inc) begin
            cntNext_s = cnt_r;
        end else if (cnt_r == LAST) begin
            cntNext_s = {COORD_W{1'b0}};
        end else begin
            cntNext_s = cnt_r + ONE;
        end
    end

    // Count register and decodes registered from the next count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r      <= {COORD_W{1'b0}};
            syncN_r    <= 1'b1;
            inActive_r <= 1'b1;
        end else begin
            cnt_r      <= cntNext_s;
            syncN_r    <= !((cntNext_s >= SYNC_START) && (cntNext_s < SYNC_END));
            inActive_r <= (cntNext_s < ACTIVE_END);
        end
    end

    assign cnt       = cnt_r;
    assign wrap      = wrap_s;
    assign sync_n    = syncN_r;
    assign in_active = inActive_r;

endmodule

// File: rtl/vga_frame_timer.sv
// VGA raster timing generator: pixel-tick divider, x/y axis counters, sync
// outputs, the vertical-blanking level screenEnd with its one-clock rise strobe,
// and a wrapping count of completed frames.
module vga_frame_timer
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic               clock,
    input  logic               reset,
    output logic               pix_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               screenEnd,
    output logic               screenEnd_pulse,
    output logic [15:0]        frame_count
);

    // A divide-by-one still needs a one-bit divider register.
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST      = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE       = DIV_W'(1);
    localparam logic [COORD_W-1:0] V_LAST_ACTIVE = COORD_W'(V_ACTIVE - 1);

    logic [DIV_W-1:0]   div_r;
    logic               pixEn_r;
    logic               screenEnd_r;
    logic               screenEndPulse_r;
    logic [15:0]        frameCount_r;

    logic [COORD_W-1:0] hCnt_s;
    logic [COORD_W-1:0] vCnt_s;
    logic               hWrap_s;
    logic               vWrap_s;
    logic               vInc_s;
    logic               hSyncN_s;
    logic               vSyncN_s;
    logic               hInActive_s;
    logic               vInActive_s;
    logic               blankStart_s;

    // Pixel-tick divider: pix_en is registered and follows the last divider phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r   <= {DIV_W{1'b0}};
            pixEn_r <= 1'b0;
        end else begin
            pixEn_r <= (div_r == DIV_LAST);
            if (div_r == DIV_LAST) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_ONE;
            end
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_hAxis (
        .clock     (clock),
        .reset     (reset),
        .inc       (pixEn_r),
        .cnt       (hCnt_s),
        .wrap      (hWrap_s),
        .sync_n    (hSyncN_s),
        .in_active (hInActive_s)
    );

    // The vertical axis steps once per line, on the tick where x wraps.
    assign vInc_s = pixEn_r && hWrap_s;

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_vAxis (
        .clock     (clock),
        .reset     (reset),
        .inc       (vInc_s),
        .cnt       (vCnt_s),
        .wrap      (vWrap_s),
        .sync_n    (vSyncN_s),
        .in_active (vInActive_s)
    );

    // y is about to step from the last visible line into vertical blanking.
    assign blankStart_s = vInc_s && (vCnt_s == V_LAST_ACTIVE);

    // Blanking level and its rise strobe, updated on the same clock as y.
    always_ff @(posedge clock) begin
        if (reset) begin
            screenEnd_r      <= 1'b0;
            screenEndPulse_r <= 1'b0;
        end else begin
            screenEndPulse_r <= blankStart_s;
            if (blankStart_s) begin
                screenEnd_r <= 1'b1;
            end else if (vWrap_s) begin
                screenEnd_r <= 1'b0;
            end else begin
                screenEnd_r <= screenEnd_r;
            end
        end
    end

    // Completed-frame counter, wrapping modulo 2^16 when y returns to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            frameCount_r <= 16'd0;
        end else if (vWrap_s) begin
            frameCount_r <= frameCount_r + 16'd1;
        end else begin
            frameCount_r <= frameCount_r;
        end
    end

    assign pix_en          = pixEn_r;
    assign x               = hCnt_s;
    assign y               = vCnt_s;
    // Both terms are flops updated on the same clock, so the product is coherent with x/y.
    assign active          = hInActive_s && vInActive_s;
    assign hsync           = hSyncN_s;
    assign vsync           = vSyncN_s;
    assign screenEnd       = screenEnd_r;
    assign screenEnd_pulse = screenEndPulse_r;
    assign frame_count     = frameCount_r;

endmodule
